// File: rtl/secure_hash_verifier.sv
// Receive-side checker: recomputes the 32-bit digest of a 128-bit message over four rounds
// and reports it with a match flag. Optional lockout on repeated failures: HASH_VERIFY_LOCKOUT_EN.
module secure_hash_verifier #(
  parameter int CNT_W     = 8,
  parameter int MAX_FAILS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     data_in,
  input  logic [31:0]      expected_hash,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      hash_out,
  output logic             match,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             locked
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    R0   = 3'd1,
    R1   = 3'd2,
    R2   = 3'd3,
    R3   = 3'd4,
    CMP  = 3'd5,
    RESP = 3'd6
  } state_t;

  state_t           state_q;
  logic [127:0]     data_q;
  logic [31:0]      exp_q;
  logic [31:0]      s0_q, s1_q, s2_q, s3_q;
  logic [31:0]      hash_q;
  logic             match_q;
  logic             res_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      hash_d;
  logic             match_d;
  logic [CNT_W-1:0] cnt_d;
  logic             lock_now;

  assign hash_d  = s0_q ^ s1_q ^ s2_q ^ s3_q;
  assign match_d = (hash_d == exp_q);
  assign cnt_d   = (!match_d && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  // Upper message half never feeds the digest.
  logic unused_hi;
  assign unused_hi = ^data_q[127:64];

`ifdef HASH_VERIFY_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic [FW-1:0] fails_q, fails_d;
  logic          locked_q, lock_d;

  always_comb begin
    fails_d = fails_q;
    lock_d  = locked_q;
    if (match_d) begin
      fails_d = '0;
    end else if (fails_q < FW'(MAX_FAILS)) begin
      fails_d = fails_q + FW'(1);
    end
    if (!match_d && (fails_d == FW'(MAX_FAILS))) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fails_q  <= '0;
      locked_q <= 1'b0;
    end else if (state_q == CMP) begin
      fails_q  <= fails_d;
      locked_q <= lock_d;
    end
  end

  assign lock_now = locked_q;
`else
  localparam int unused_max_fails = MAX_FAILS;
  assign lock_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      exp_q       <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      hash_q      <= '0;
      match_q     <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= !lock_now;
          if (in_valid && in_ready_q) begin
            data_q     <= data_in;
            exp_q      <= expected_hash;
            s0_q       <= 32'h6a09e667;
            s1_q       <= 32'hbb67ae85;
            s2_q       <= 32'h3c6ef372;
            s3_q       <= 32'ha54ff53a;
            in_ready_q <= 1'b0;
            state_q    <= R0;
          end
        end
        R0: begin
          s0_q    <= s0_q ^ data_q[31:0];
          state_q <= R1;
        end
        R1: begin
          s1_q    <= s1_q + data_q[63:32];
          state_q <= R2;
        end
        R2: begin
          s2_q    <= {s2_q[30:0], 1'b0};
          state_q <= R3;
        end
        R3: begin
          s3_q    <= {1'b0, s3_q[31:1]};
          state_q <= CMP;
        end
        CMP: begin
          hash_q      <= hash_d;
          match_q     <= match_d;
          cnt_q       <= cnt_d;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // Result is held until the consumer takes it.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= !lock_now;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign res_valid    = res_valid_q;
  assign hash_out     = hash_q;
  assign match        = match_q;
  assign mismatch_cnt = cnt_q;
  assign locked       = lock_now;

endmodule
